// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch stage: opcode/func constants, the FSM state
// type and the layout of one fetch-queue entry.
package fetch_sequencer_pkg;

  localparam int PC_W   = 32;
  localparam int OP_W   = 6;
  localparam int FUNC_W = 6;
  localparam int REG_W  = 5;
  localparam int VALC_W = 32;

  localparam logic [OP_W-1:0]   OP_RTYPE     = 6'b000000;
  localparam logic [FUNC_W-1:0] FUNC_SYSCALL = 6'b001100;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [OP_W-1:0]   op;
    logic [FUNC_W-1:0] func;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  rd;
    logic [VALC_W-1:0] val_c;
  } fetch_entry_t;

  function automatic logic is_halt_instr(input logic [OP_W-1:0]   op,
                                         input logic [FUNC_W-1:0] func,
                                         input logic [FUNC_W-1:0] halt_func);
    return (op == OP_RTYPE) && (func == halt_func);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small power-of-two FIFO of fetch entries. Flush empties it in one cycle;
// the caller guarantees push only when not full (or popping) and pop only when not empty.
module fetch_queue
  import fetch_sequencer_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  fetch_entry_t     wr_entry,
  output fetch_entry_t     rd_entry,
  output logic [CNT_W-1:0] count
);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      // Storage is left alone: the head contents are don't-care while empty.
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[tail] <= wr_entry;
        tail      <= tail + 1'b1;
      end
      if (pop) head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rd_entry = mem[head];

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch stage: owns the fetch PC, buffers instr_mem output in fetch_queue and
// hands entries to decode; halts on SYSCALL until a redirect restarts fetch.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          DEPTH     = 2,
  parameter logic [5:0]  HALT_FUNC = FUNC_SYSCALL
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] F_valP,
  input  logic [5:0]  f_op,
  input  logic [5:0]  f_func,
  input  logic [4:0]  f_rs,
  input  logic [4:0]  f_rt,
  input  logic [4:0]  f_rd,
  input  logic [31:0] f_valC,
  input  logic        e_redirect,
  input  logic [31:0] e_target,
  input  logic        d_ready,
  output logic        d_valid,
  output logic [31:0] d_pc,
  output logic [5:0]  d_op,
  output logic [5:0]  d_func,
  output logic [4:0]  d_rs,
  output logic [4:0]  d_rt,
  output logic [4:0]  d_rd,
  output logic [31:0] d_valC,
  output logic        halted
);

  localparam int              CNT_W     = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  // Decode handshake: an entry transfers on any rising edge where d_valid and
  // d_ready are both high; d_valid never depends on d_ready.
  fetch_state_e     state;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;
  fetch_entry_t     wr_entry;
  fetch_entry_t     head;

  assign d_valid = (count != '0);
  assign pop     = d_valid & d_ready;
  assign push    = (state == ST_RUN) & ~e_redirect & ((count < DEPTH_CNT) | pop);

  assign wr_entry = '{pc: F_valP, op: f_op, func: f_func, rs: f_rs,
                      rt: f_rt, rd: f_rd, val_c: f_valC};

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk      (clk),
    .reset    (reset),
    .flush    (e_redirect),
    .push     (push),
    .pop      (pop),
    .wr_entry (wr_entry),
    .rd_entry (head),
    .count    (count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      F_valP <= RESET_PC;
      state  <= ST_RUN;
    end else if (e_redirect) begin
      F_valP <= {e_target[31:2], 2'b00};
      state  <= ST_RUN;
    end else if (push) begin
      F_valP <= F_valP + 32'd4;
      // The SYSCALL itself is queued; fetch stops from the next cycle on.
      if (is_halt_instr(f_op, f_func, HALT_FUNC)) state <= ST_HALT;
    end
  end

  assign halted = (state == ST_HALT);
  assign d_pc   = head.pc;
  assign d_op   = head.op;
  assign d_func = head.func;
  assign d_rs   = head.rs;
  assign d_rt   = head.rt;
  assign d_rd   = head.rd;
  assign d_valC = head.val_c;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: a queue-level reference model predicts the fetch
// PC, halt flag and the entries decode must receive; a negedge monitor compares.
module tb_fetch_sequencer;
  import fetch_sequencer_pkg::*;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [5:0]  HALT_F   = 6'h0C;
  localparam int          EW       = 91;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] F_valP;
  logic [5:0]  f_op, f_func;
  logic [4:0]  f_rs, f_rt, f_rd;
  logic [31:0] f_valC;
  logic        e_redirect;
  logic [31:0] e_target;
  logic        d_ready;
  logic        d_valid;
  logic [31:0] d_pc;
  logic [5:0]  d_op, d_func;
  logic [4:0]  d_rs, d_rt, d_rd;
  logic [31:0] d_valC;
  logic        halted;

  always #5 clk = ~clk;

  fetch_sequencer #(.RESET_PC(RESET_PC), .DEPTH(DEPTH), .HALT_FUNC(HALT_F)) dut (
    .clk(clk), .reset(reset), .F_valP(F_valP),
    .f_op(f_op), .f_func(f_func), .f_rs(f_rs), .f_rt(f_rt), .f_rd(f_rd), .f_valC(f_valC),
    .e_redirect(e_redirect), .e_target(e_target), .d_ready(d_ready),
    .d_valid(d_valid), .d_pc(d_pc), .d_op(d_op), .d_func(d_func),
    .d_rs(d_rs), .d_rt(d_rt), .d_rd(d_rd), .d_valC(d_valC), .halted(halted)
  );

  // instr_mem stand-in: 64-word table indexed by address bits [7:2]
  logic [5:0]  t_op   [64];
  logic [5:0]  t_func [64];
  logic [4:0]  t_rs   [64];
  logic [4:0]  t_rt   [64];
  logic [4:0]  t_rd   [64];
  logic [31:0] t_valc [64];

  always_comb begin
    f_op   = t_op[F_valP[7:2]];
    f_func = t_func[F_valP[7:2]];
    f_rs   = t_rs[F_valP[7:2]];
    f_rt   = t_rt[F_valP[7:2]];
    f_rd   = t_rd[F_valP[7:2]];
    f_valC = t_valc[F_valP[7:2]];
  end

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  logic [EW-1:0] exp_q[$];
  logic [31:0]   m_pc;
  bit            m_halt;

  function automatic logic [EW-1:0] entry_at(input logic [31:0] a);
    return {a, t_op[a[7:2]], t_func[a[7:2]], t_rs[a[7:2]], t_rt[a[7:2]],
            t_rd[a[7:2]], t_valc[a[7:2]]};
  endfunction

  task automatic check(input string name, input logic [EW-1:0] got, input logic [EW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: compare outputs against the model, then advance the model using
  // the inputs that the next rising edge will see.
  always @(negedge clk) begin
    bit m_valid;
    bit m_pop;
    bit m_push;
    m_valid = (exp_q.size() != 0);
    if (mon_en) begin
      check("F_valP", EW'(F_valP), EW'(m_pc));
      check("halted", EW'(halted), EW'(m_halt));
      check("d_valid", EW'(d_valid), EW'(m_valid));
      if (m_valid && d_ready)
        check("d_entry", {d_pc, d_op, d_func, d_rs, d_rt, d_rd, d_valC}, exp_q[0]);
    end
    if (reset) begin
      exp_q.delete();
      m_pc   = RESET_PC;
      m_halt = 1'b0;
    end else if (e_redirect) begin
      exp_q.delete();
      m_pc   = {e_target[31:2], 2'b00};
      m_halt = 1'b0;
    end else begin
      m_pop  = m_valid && d_ready;
      m_push = !m_halt && ((exp_q.size() < DEPTH) || m_pop);
      if (m_pop) void'(exp_q.pop_front());
      if (m_push) begin
        exp_q.push_back(entry_at(m_pc));
        if (t_op[m_pc[7:2]] == 6'd0 && t_func[m_pc[7:2]] == HALT_F) m_halt = 1'b1;
        m_pc = m_pc + 32'd4;
      end
    end
  end

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic redirect_to(input logic [31:0] tgt);
    e_redirect = 1'b1;
    e_target   = tgt;
    cycles(1);
    e_redirect = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      t_op[i]   = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom);
      t_func[i] = 6'($urandom);
      if (t_op[i] == 6'd0 && t_func[i] == HALT_F) t_func[i] = 6'd0;
      t_rs[i]   = 5'($urandom);
      t_rt[i]   = 5'($urandom);
      t_rd[i]   = 5'($urandom);
      t_valc[i] = $urandom;
    end
    // SYSCALLs at 0x14 (directed halt) and a few spots reached by random runs
    t_op[5]  = 6'd0; t_func[5]  = HALT_F;
    t_op[40] = 6'd0; t_func[40] = HALT_F;
    t_op[50] = 6'd0; t_func[50] = HALT_F;

    reset = 1'b1; e_redirect = 1'b0; e_target = '0; d_ready = 1'b0;
    cycles(2);
    mon_en = 1'b1;
    check("reset_d_fields", {d_valid, d_pc, d_op, d_func, d_rs, d_rt, d_rd, d_valC}, '0);
    check("reset_pc", EW'(F_valP), EW'(RESET_PC));

    // Streaming from reset into the SYSCALL at 0x14, then frozen while halted
    reset = 1'b0; d_ready = 1'b1;
    cycles(12);
    check("halt_frozen_pc", EW'(F_valP), EW'(32'd24));
    check("halt_flag", EW'(halted), EW'(1'b1));

    // Redirect out of HALT resumes at the target
    redirect_to(32'h3C);
    check("resume_pc", EW'(F_valP), EW'(32'h3C));
    check("resume_halted", EW'(halted), EW'(1'b0));
    cycles(4);

    // Back-pressure from reset: two entries then PC stalls at 8
    reset = 1'b1; d_ready = 1'b0;
    cycles(1);
    reset = 1'b0;
    cycles(4);
    check("bp_stall_pc", EW'(F_valP), EW'(32'd8));
    d_ready = 1'b1;
    cycles(1);
    d_ready = 1'b0;
    cycles(2);
    check("bp_pop_push_pc", EW'(F_valP), EW'(32'd12));

    // Redirect while full, unaligned target
    redirect_to(32'h43);
    check("flush_valid", EW'(d_valid), EW'(1'b0));
    check("flush_pc", EW'(F_valP), EW'(32'h40));
    cycles(1);
    check("flush_first_pc", EW'(d_pc), EW'(32'h40));

    // Reset mid-operation with two queued entries
    cycles(1);
    redirect_to(32'h28);
    cycles(2);
    check("pre_reset_pc", EW'(F_valP), EW'(32'h30));
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
    check("mid_reset_valid", EW'(d_valid), EW'(1'b0));
    check("mid_reset_pc", EW'(F_valP), EW'(RESET_PC));
    check("mid_reset_halted", EW'(halted), EW'(1'b0));

    // PC wrap across 2^32
    d_ready = 1'b1;
    redirect_to(32'hFFFF_FFF8);
    cycles(3);
    check("wrap_pc", EW'(F_valP), EW'(32'd4));

    // Randomised traffic
    for (int i = 0; i < 2000; i++) begin
      d_ready    = ($urandom_range(0, 3) != 0);
      e_redirect = ($urandom_range(0, 24) == 0);
      e_target   = $urandom;
      reset      = ($urandom_range(0, 149) == 0);
      cycles(1);
    end
    reset = 1'b0; e_redirect = 1'b0;
    cycles(2);
    mon_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
